// File: rtl/uart_pkg.sv
// Shared UART/ALU definitions: default widths, FSM state encoding and ALU opcodes.
// Used by uart_alu_if and by anything that models the external ALU.
package uart_pkg;

  localparam int NB_DATA_DEF = 8;
  localparam int NB_OP_DEF   = 6;

  typedef enum logic [2:0] {
    S_WAIT_A  = 3'd0,
    S_WAIT_B  = 3'd1,
    S_WAIT_OP = 3'd2,
    S_EXEC    = 3'd3,
    S_SEND    = 3'd4,
    S_WAIT_TX = 3'd5
  } state_t;

  localparam logic [5:0] OP_ADD = 6'h20;
  localparam logic [5:0] OP_SUB = 6'h22;
  localparam logic [5:0] OP_AND = 6'h24;
  localparam logic [5:0] OP_OR  = 6'h25;
  localparam logic [5:0] OP_XOR = 6'h26;
  localparam logic [5:0] OP_SRA = 6'h03;
  localparam logic [5:0] OP_SRL = 6'h02;
  localparam logic [5:0] OP_NOR = 6'h27;

endpackage

// File: rtl/uart_alu_if_timeout.sv
// Clearable saturating cycle counter; tc is high while enabled and parked at TIMEOUT_CYCLES-1.
// Latency: tc is a combinational decode of the count register.
module uart_alu_if_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int unsigned NB_CNT = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [NB_CNT-1:0] TC_VAL = NB_CNT'(TIMEOUT_CYCLES - 1);

  logic [NB_CNT-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && (count != TC_VAL)) begin
      count <= count + 1'b1;
    end
  end

  assign tc = en && (count == TC_VAL);

endmodule

// File: rtl/uart_alu_if.sv
// Collects A, B, opcode from the UART rx, registers the ALU result and hands it to uart_tx.
// Optional inter-byte timeout back to S_WAIT_A when UART_ALU_IF_TIMEOUT_EN is defined.
module uart_alu_if
  import uart_pkg::*;
#(
  parameter int NB_DATA        = NB_DATA_DEF,
  parameter int NB_OP          = NB_OP_DEF,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  output logic [NB_DATA-1:0] o_alu_a,
  output logic [NB_DATA-1:0] o_alu_b,
  output logic [NB_OP-1:0]   o_alu_op,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  input  logic               i_tx_done,
  output logic               o_busy,
  output logic               o_rx_drop
);

  state_t state;
  state_t state_next;
  logic   timeout;
  logic   load_a;
  logic   load_b;
  logic   load_op;
  logic   load_res;
  logic   drop;

`ifdef UART_ALU_IF_TIMEOUT_EN
  logic cnt_clr;
  logic cnt_en;

  // Any accepted byte or state move restarts the inter-byte window.
  assign cnt_en  = (state == S_WAIT_B) || (state == S_WAIT_OP);
  assign cnt_clr = i_rx_done || (state_next != state);

  uart_alu_if_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk (clk),
    .rst (i_rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .tc  (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state <= S_WAIT_A;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load_a     = 1'b0;
    load_b     = 1'b0;
    load_op    = 1'b0;
    load_res   = 1'b0;
    drop       = 1'b0;
    o_tx_start = 1'b0;
    o_busy     = 1'b0;
    unique case (state)
      S_WAIT_A: begin
        if (i_rx_done) begin
          load_a     = 1'b1;
          state_next = S_WAIT_B;
        end
      end
      // A byte landing on the terminal count still wins over the timeout.
      S_WAIT_B: begin
        if (i_rx_done) begin
          load_b     = 1'b1;
          state_next = S_WAIT_OP;
        end else if (timeout) begin
          state_next = S_WAIT_A;
        end
      end
      S_WAIT_OP: begin
        if (i_rx_done) begin
          load_op    = 1'b1;
          state_next = S_EXEC;
        end else if (timeout) begin
          state_next = S_WAIT_A;
        end
      end
      S_EXEC: begin
        o_busy     = 1'b1;
        load_res   = 1'b1;
        drop       = i_rx_done;
        state_next = S_SEND;
      end
      // tx_done coincident with the start pulse is ignored by construction.
      S_SEND: begin
        o_busy     = 1'b1;
        o_tx_start = 1'b1;
        drop       = i_rx_done;
        state_next = S_WAIT_TX;
      end
      S_WAIT_TX: begin
        o_busy = 1'b1;
        drop   = i_rx_done;
        if (i_tx_done) begin
          state_next = S_WAIT_A;
        end
      end
      default: begin
        state_next = S_WAIT_A;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      o_alu_a   <= '0;
      o_alu_b   <= '0;
      o_alu_op  <= '0;
      o_tx_data <= '0;
      o_rx_drop <= 1'b0;
    end else begin
      if (load_a) begin
        o_alu_a <= i_rx_data;
      end
      if (load_b) begin
        o_alu_b <= i_rx_data;
      end
      if (load_op) begin
        o_alu_op <= i_rx_data[NB_OP-1:0];
      end
      if (load_res) begin
        o_tx_data <= i_alu_result;
      end
      o_rx_drop <= drop;
    end
  end

endmodule

// File: doc/uart_alu_if.md
Name: uart_alu_if

Overview:
- Protocol interface between the UART receiver, the external combinational ALU and uart_tx.
- Collects three received bytes in order: operand A, operand B, opcode.
- Drives the ALU with registered operands and samples the result.
- Hands the result byte to the transmitter through a start/done handshake.
- Sits directly upstream of uart_tx: its o_tx_data and o_tx_start feed the transmitter's data and start inputs.

Parameters:
- NB_DATA, 8, width of UART bytes, ALU operands and ALU result.
- NB_OP, 6, width of the ALU opcode; taken from the low NB_OP bits of the third byte.
- TIMEOUT_CYCLES, 1000000, inter-byte timeout in clk cycles; used only when UART_ALU_IF_TIMEOUT_EN is defined.

Ports:
- clk  input  1  system clock; every register is on its rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_rx_data  input  NB_DATA  received byte; valid while i_rx_done is high.
- i_rx_done  input  1  one-cycle pulse per received byte.
- o_alu_a  output  NB_DATA  registered operand A.
- o_alu_b  output  NB_DATA  registered operand B.
- o_alu_op  output  NB_OP  registered opcode.
- i_alu_result  input  NB_DATA  combinational ALU result.
- o_tx_data  output  NB_DATA  byte to transmit; held stable from the o_tx_start pulse until i_tx_done.
- o_tx_start  output  1  one-cycle pulse requesting transmission.
- i_tx_done  input  1  one-cycle pulse from uart_tx when the stop bit completes.
- o_busy  output  1  high in S_EXEC, S_SEND and S_WAIT_TX.
- o_rx_drop  output  1  one-cycle pulse when an rx byte is discarded.

Behaviour:
- Reset: state S_WAIT_A; o_alu_a, o_alu_b, o_alu_op, o_tx_data = 0; o_tx_start, o_busy, o_rx_drop = 0. Reset wins over every other event, including mid-transfer; an in-flight transmission is abandoned.
- State S_WAIT_A: on i_rx_done, latch i_rx_data into o_alu_a, go to S_WAIT_B.
- State S_WAIT_B: on i_rx_done, latch into o_alu_b, go to S_WAIT_OP.
- State S_WAIT_OP: on i_rx_done, latch i_rx_data[NB_OP-1:0] into o_alu_op, go to S_EXEC.
- State S_EXEC: lasts exactly one cycle (operands are stable and the ALU settles). Register i_alu_result into o_tx_data, go to S_SEND.
- State S_SEND: assert o_tx_start for exactly one cycle, go to S_WAIT_TX.
- State S_WAIT_TX: on i_tx_done, go to S_WAIT_A.
  - o_tx_data is unchanged until then.
  - An i_tx_done in the same cycle as the o_tx_start pulse is ignored.
- Latency: the o_tx_start pulse comes 2 cycles after the i_rx_done of the opcode byte.
- Operand and opcode registers hold their values after the transaction until overwritten.
- i_rx_done in S_EXEC, S_SEND or S_WAIT_TX: the byte is dropped, o_rx_drop pulses the next cycle, and the state is unchanged.
- i_rx_done and i_tx_done in the same cycle in S_WAIT_TX: go to S_WAIT_A and drop the byte (o_rx_drop pulses). The first byte must arrive after done.
- i_rx_done high for more than one cycle is a protocol violation and need not be handled.
- No arithmetic is done in this block; widths pass through unchanged.

Optional Feature:
- Macro UART_ALU_IF_TIMEOUT_EN.
- Defined:
  - A counter runs while in S_WAIT_B or S_WAIT_OP and is cleared on each i_rx_done and on every state change.
  - When it reaches TIMEOUT_CYCLES-1, the state returns to S_WAIT_A. Operand registers are kept; nothing is transmitted.
  - The timeout is evaluated after i_rx_done in the same cycle: a byte arriving on the terminal count is accepted.
- Not defined: no counter is present, and the block waits indefinitely for B and the opcode.

Decomposition:
- Shared package uart_pkg:
  - NB_DATA and NB_OP defaults.
  - State encoding constants S_WAIT_A=3'd0, S_WAIT_B=3'd1, S_WAIT_OP=3'd2, S_EXEC=3'd3, S_SEND=3'd4, S_WAIT_TX=3'd5.
  - ALU opcode constants (ADD=6'h20, SUB=6'h22, AND=6'h24, OR=6'h25, XOR=6'h26, SRA=6'h03, SRL=6'h02, NOR=6'h27) for the bench and the ALU.
- One sub-module: uart_alu_if_timeout, a clearable saturating counter with a terminal-count pulse. It is instantiated only under the macro.

Test Plan:
- Basic transaction: rx 0x05, 0x03, 0x20 with an ALU model returning a+b → o_alu_a=0x05, o_alu_b=0x03, o_alu_op=0x20; o_tx_start pulses 2 cycles after the third i_rx_done; o_tx_data=0x08 held until i_tx_done; state returns to S_WAIT_A.
- Back-to-back: rx 0xF0, 0x0F, 0x24 (AND → 0x00), then after i_tx_done rx 0xFF, 0x01, 0x20 → o_tx_data 0x00 then 0x00 (wrap of 0xFF+0x01); two start pulses total.
- Drop while busy: send one byte during S_WAIT_TX → o_rx_drop pulses once, no state change, and the next transaction decodes correctly.
- Reset mid-operation: assert i_rst after byte A → every output is 0 and state is S_WAIT_A; the next three bytes form a fresh transaction.
- Simultaneous done events: i_tx_done and i_rx_done in the same cycle → o_rx_drop pulses and the state is S_WAIT_A.
- Timeout (UART_ALU_IF_TIMEOUT_EN, TIMEOUT_CYCLES=16):
  - Byte A, then 16 idle cycles → back to S_WAIT_A with no o_tx_start.
  - Repeat with a byte at cycle 15 → accepted as B.
